// File: rtl/serial_byte_receiver_pkg.sv
// Shared definitions for the receive-side framing blocks: FSM encoding,
// serial line levels and the default frame width.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rxState_t;

    localparam logic LINE_IDLE         = 1'b1;
    localparam logic START_LEVEL       = 1'b0;
    localparam int   DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/serial_byte_receiver_bit_synchronizer.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// level is a parameter so idle-high and idle-low lines can both use it.
module bit_synchronizer #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_LEVEL;
            r_sync <= RESET_LEVEL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/serial_byte_receiver.sv
// Strobe-driven serial frame receiver: start/data/parity/stop framing with a
// valid/ready output register and one-cycle error pulses.
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 serial_in,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    logic                 w_rx;
    rxState_t             r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_bitCnt;
    logic                 r_parAcc;
    logic                 r_parBad;
    logic [DATA_BITS-1:0] r_dataOut;
    logic                 r_dataValid;
    logic                 r_frameErr;
    logic                 r_parityErr;
    logic                 r_overrun;
    logic                 r_busy;

    bit_synchronizer #(
        .RESET_LEVEL(LINE_IDLE)
    ) u_rxSync (
        .clock  (clock),
        .reset  (reset),
        .i_async(serial_in),
        .o_sync (w_rx)
    );

    // Framing FSM and output register share one block so that a load on the
    // stop strobe takes priority over a plain consumer acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_parAcc    <= 1'b0;
            r_parBad    <= 1'b0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_dataValid && data_ready) begin
                r_dataValid <= 1'b0;
            end
            if (enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rx == START_LEVEL) begin
                            r_state  <= ST_DATA;
                            r_bitCnt <= '0;
                            r_parAcc <= 1'b0;
                            r_parBad <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_parAcc <= r_parAcc ^ w_rx;
                        r_bitCnt <= r_bitCnt + CW'(1);
                        if (r_bitCnt == LAST_BIT) begin
                            r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        r_parBad <= r_parAcc ^ w_rx;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx != LINE_IDLE) begin
                            r_frameErr <= 1'b1;
                        end else if (PARITY_EN && r_parBad) begin
                            r_parityErr <= 1'b1;
                        end else if (!r_dataValid || data_ready) begin
                            r_dataOut   <= r_shift;
                            r_dataValid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_out     = r_dataOut;
    assign data_valid   = r_dataValid;
    assign frame_error  = r_frameErr;
    assign parity_error = r_parityErr;
    assign overrun      = r_overrun;
    assign busy         = r_busy;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: one instance without parity and one with
// even parity, checked every cycle against a frame-level reference model.
module tb_serial_byte_receiver;

    localparam int DB = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          dataReady = 1'b0;
    logic          serialIn [2];
    logic [DB-1:0] dutData  [2];
    logic          dutValid [2];
    logic          dutFe    [2];
    logic          dutPe    [2];
    logic          dutOv    [2];
    logic          dutBusy  [2];

    int  checks = 0;
    int  errors = 0;
    bit  checking = 1'b0;
    int  strobeCnt = 0;
    bit  bitQ0[$];
    bit  bitQ1[$];
    int  feSeen[2];
    int  peSeen[2];
    int  ovSeen[2];
    int  busySeen[2];

    // Reference model state, per channel (channel 1 carries a parity bit)
    logic          mD1 [2];
    logic          mD2 [2];
    bit            mIn [2];
    int            mCnt[2];
    logic [15:0]   mBits[2];
    logic [DB-1:0] mData[2];
    bit            mValid[2];
    bit            mFe[2];
    bit            mPe[2];
    bit            mOv[2];
    bit            mBusy[2];

    serial_byte_receiver #(.DATA_BITS(DB), .PARITY_EN(1'b0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .serial_in   (serialIn[0]),
        .data_ready  (dataReady),
        .data_out    (dutData[0]),
        .data_valid  (dutValid[0]),
        .frame_error (dutFe[0]),
        .parity_error(dutPe[0]),
        .overrun     (dutOv[0]),
        .busy        (dutBusy[0])
    );

    serial_byte_receiver #(.DATA_BITS(DB), .PARITY_EN(1'b1)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .serial_in   (serialIn[1]),
        .data_ready  (dataReady),
        .data_out    (dutData[1]),
        .data_valid  (dutValid[1]),
        .frame_error (dutFe[1]),
        .parity_error(dutPe[1]),
        .overrun     (dutOv[1]),
        .busy        (dutBusy[1])
    );

    always #5 clock = ~clock;

    initial begin
        serialIn[0] = 1'b1;
        serialIn[1] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mD1[c] = 1'b1; mD2[c] = 1'b1; mIn[c] = 1'b0; mCnt[c] = 0;
            mBits[c] = '0; mData[c] = '0; mValid[c] = 1'b0;
            mFe[c] = 1'b0; mPe[c] = 1'b0; mOv[c] = 1'b0; mBusy[c] = 1'b0;
            feSeen[c] = 0; peSeen[c] = 0; ovSeen[c] = 0; busySeen[c] = 0;
        end
    end

    // Eight-clock bit-period counter plus line driver: a new bit goes onto
    // each line right after the strobe that sampled the previous one.
    always @(posedge clock) begin
        #2;
        if (enable) begin
            serialIn[0] = (bitQ0.size() > 0) ? bitQ0.pop_front() : 1'b1;
            serialIn[1] = (bitQ1.size() > 0) ? bitQ1.pop_front() : 1'b1;
        end
        strobeCnt = (strobeCnt + 1) % 8;
        enable = (strobeCnt == 0);
    end

    // Frame-level model: collect sampled bits after a low start sample, judge
    // the frame once start+data+parity+stop strobes have gone by.
    always @(posedge clock or negedge reset) begin : model
        logic rx;
        bit   done;
        bit   complete;
        bit   stopBit;
        bit   parityOk;
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                mD1[c] = 1'b1; mD2[c] = 1'b1; mIn[c] = 1'b0; mCnt[c] = 0;
                mBits[c] = '0; mData[c] = '0; mValid[c] = 1'b0;
                mFe[c] = 1'b0; mPe[c] = 1'b0; mOv[c] = 1'b0; mBusy[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                rx = mD2[c];
                mD2[c] = mD1[c];
                mD1[c] = serialIn[c];
                mFe[c] = 1'b0; mPe[c] = 1'b0; mOv[c] = 1'b0;
                done = 1'b0;
                complete = 1'b0;
                if (enable) begin
                    if (!mIn[c]) begin
                        if (rx == 1'b0) begin
                            mIn[c] = 1'b1;
                            mCnt[c] = 0;
                        end
                    end else begin
                        mBits[c][mCnt[c]] = rx;
                        mCnt[c]++;
                        if (mCnt[c] == DB + c + 1) begin
                            mIn[c] = 1'b0;
                            done = 1'b1;
                        end
                    end
                end
                if (done) begin
                    stopBit = mBits[c][DB + c];
                    parityOk = (c == 0) || (((^mBits[c][DB-1:0]) ^ mBits[c][DB]) == 1'b0);
                    if (!stopBit) mFe[c] = 1'b1;
                    else if (!parityOk) mPe[c] = 1'b1;
                    else complete = 1'b1;
                end
                if (complete) begin
                    if (!mValid[c] || dataReady) begin
                        mData[c] = mBits[c][DB-1:0];
                        mValid[c] = 1'b1;
                    end else begin
                        mOv[c] = 1'b1;
                    end
                end else if (mValid[c] && dataReady) begin
                    mValid[c] = 1'b0;
                end
                mBusy[c] = mIn[c];
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, plus pulse bookkeeping used
    // by the directed literal checks.
    always @(negedge clock) begin
        if (checking) begin
            for (int c = 0; c < 2; c++) begin
                checkOutput($sformatf("ch%0d data_out", c), int'(dutData[c]), int'(mData[c]));
                checkOutput($sformatf("ch%0d data_valid", c), int'(dutValid[c]), int'(mValid[c]));
                checkOutput($sformatf("ch%0d frame_error", c), int'(dutFe[c]), int'(mFe[c]));
                checkOutput($sformatf("ch%0d parity_error", c), int'(dutPe[c]), int'(mPe[c]));
                checkOutput($sformatf("ch%0d overrun", c), int'(dutOv[c]), int'(mOv[c]));
                checkOutput($sformatf("ch%0d busy", c), int'(dutBusy[c]), int'(mBusy[c]));
                if (dutFe[c] === 1'b1) feSeen[c]++;
                if (dutPe[c] === 1'b1) peSeen[c]++;
                if (dutOv[c] === 1'b1) ovSeen[c]++;
                if (dutBusy[c] === 1'b1) busySeen[c]++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #3;
    endtask

    task automatic queueFrame(input int c, input logic [7:0] d, input bit parBit, input bit stopBit);
        logic [7:0] bits;
        bits = d;
        if (c == 0) bitQ0.push_back(1'b0); else bitQ1.push_back(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (c == 0) bitQ0.push_back(bits[i]); else bitQ1.push_back(bits[i]);
        end
        if (c == 1) bitQ1.push_back(parBit);
        if (c == 0) bitQ0.push_back(stopBit); else bitQ1.push_back(stopBit);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout actual=waiting required=done", name);
    endtask

    task automatic waitIdle(input int limit, input bit randReady);
        int n;
        n = 0;
        while (!(bitQ0.size() == 0 && bitQ1.size() == 0 && dutBusy[0] === 1'b0 &&
                 dutBusy[1] === 1'b0) && n < limit) begin
            if (randReady) dataReady = ($urandom_range(0, 2) == 0);
            tick();
            n++;
        end
        if (n >= limit) timeoutFail("waitIdle");
        dataReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic applyStimulus(input int c, input logic [7:0] d, input bit parBit, input bit stopBit);
        queueFrame(c, d, parBit, stopBit);
        waitIdle(400, 1'b0);
    endtask

    task automatic pulseReady();
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
    endtask

    initial begin
        int feBase;
        int peBase;
        int ovBase;
        int busyBase;
        int n;
        logic [7:0] d;
        logic [7:0] heldData;

        repeat (3) tick();
        checking = 1'b1;
        tick();
        checkOutput("reset data_out", int'(dutData[0]), 0);
        checkOutput("reset data_valid", int'(dutValid[0]), 0);
        checkOutput("reset busy", int'(dutBusy[1]), 0);
        reset = 1'b1;
        repeat (4) tick();

        // 0xA5 held with no consumer, then accepted in one cycle
        applyStimulus(0, 8'hA5, 1'b0, 1'b1);
        repeat (100) tick();
        checkOutput("A5 data_out", int'(dutData[0]), 'hA5);
        checkOutput("A5 data_valid", int'(dutValid[0]), 1);
        checkOutput("A5 model", int'(mData[0]), 'hA5);
        pulseReady();
        checkOutput("A5 accepted", int'(dutValid[0]), 0);

        // Stop bit low
        feBase = feSeen[0];
        applyStimulus(0, 8'h3C, 1'b0, 1'b0);
        checkOutput("3C frame_error pulses", feSeen[0] - feBase, 1);
        checkOutput("3C data_valid", int'(dutValid[0]), 0);
        checkOutput("3C busy", int'(dutBusy[0]), 0);

        // Back-to-back with no consumer: second byte dropped
        ovBase = ovSeen[0];
        queueFrame(0, 8'h11, 1'b0, 1'b1);
        queueFrame(0, 8'h22, 1'b0, 1'b1);
        waitIdle(400, 1'b0);
        checkOutput("11/22 overrun pulses", ovSeen[0] - ovBase, 1);
        checkOutput("11/22 data_out kept", int'(dutData[0]), 'h11);
        pulseReady();

        // Back-to-back with acceptance on the completion edge of 0x22
        ovBase = ovSeen[0];
        queueFrame(0, 8'h11, 1'b0, 1'b1);
        queueFrame(0, 8'h22, 1'b0, 1'b1);
        n = 0;
        while (bitQ0.size() != 0 && n < 400) begin tick(); n++; end
        if (n >= 400) timeoutFail("queue drain");
        n = 0;
        while (enable !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) timeoutFail("stop strobe");
        pulseReady();
        waitIdle(100, 1'b0);
        checkOutput("22 replaced data_out", int'(dutData[0]), 'h22);
        checkOutput("22 no overrun", ovSeen[0] - ovBase, 0);
        checkOutput("22 data_valid", int'(dutValid[0]), 1);
        pulseReady();

        // Even parity on channel 1
        applyStimulus(1, 8'h07, 1'b1, 1'b1);
        checkOutput("07 good parity data_out", int'(dutData[1]), 'h07);
        checkOutput("07 good parity valid", int'(dutValid[1]), 1);
        pulseReady();
        peBase = peSeen[1];
        applyStimulus(1, 8'h07, 1'b0, 1'b1);
        checkOutput("07 bad parity pulses", peSeen[1] - peBase, 1);
        checkOutput("07 bad parity valid", int'(dutValid[1]), 0);

        // Reset in the middle of 0xFF, then a clean 0x5A
        queueFrame(0, 8'hFF, 1'b0, 1'b1);
        n = 0;
        while (dutBusy[0] !== 1'b1 && n < 40) begin tick(); n++; end
        if (n >= 40) timeoutFail("FF start");
        repeat (4) begin
            n = 0;
            while (enable !== 1'b1 && n < 20) begin tick(); n++; end
            if (n >= 20) timeoutFail("FF data strobe");
            tick();
        end
        reset = 1'b0;
        bitQ0.delete();
        serialIn[0] = 1'b1;
        #1;
        checkOutput("midreset busy", int'(dutBusy[0]), 0);
        checkOutput("midreset data_out", int'(dutData[0]), 0);
        checkOutput("midreset data_valid", int'(dutValid[1]), 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        feBase = feSeen[0];
        ovBase = ovSeen[0];
        applyStimulus(0, 8'h5A, 1'b0, 1'b1);
        checkOutput("5A data_out", int'(dutData[0]), 'h5A);
        checkOutput("5A no errors", (feSeen[0] - feBase) + (ovSeen[0] - ovBase), 0);

        // Idle line: nothing may happen
        busyBase = busySeen[0] + busySeen[1];
        heldData = dutData[0];
        repeat (200) tick();
        checkOutput("idle busy cycles", busySeen[0] + busySeen[1] - busyBase, 0);
        checkOutput("idle data_out", int'(dutData[0]), int'(heldData));
        pulseReady();

        // Randomized frames on both channels with a random consumer
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 2; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        if (c == 0) bitQ0.push_back(1'b1); else bitQ1.push_back(1'b1);
                    end
                    d = 8'($urandom_range(0, 255));
                    queueFrame(c, d, (^d) ^ ($urandom_range(0, 4) == 0),
                               $urandom_range(0, 5) != 0);
                end
            end
            waitIdle(800, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Receive-side framing stage that consumes the one-cycle `enable` strobe produced by the eight-clock counter (one strobe per bit period). It samples a serial line once per strobe, recognises start/data/parity/stop bits, and presents each received byte on a valid/ready output with error flags. It sits between the bit-period counter and whatever logic consumes received bytes.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8, sent LSB first.
- `PARITY_EN`, default 0: 0 means no parity bit; 1 means an even-parity bit follows the data bits.
- `clock` input 1: single clock for all logic; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces the reset state immediately.
- `enable` input 1: bit-period strobe from the eight-clock counter; high for exactly one `clock` cycle per bit period.
- `serial_in` input 1: asynchronous serial line; idles high.
- `data_out` output `DATA_BITS`: last accepted byte. Reset value 0.
- `data_valid` output 1: `data_out` holds an unconsumed byte. Reset value 0.
- `data_ready` input 1: consumer accepts `data_out` in any cycle where `data_valid` and `data_ready` are both 1.
- `frame_error` output 1: one-cycle pulse when the stop bit samples 0. Reset value 0.
- `parity_error` output 1: one-cycle pulse on parity mismatch, only when `PARITY_EN` is 1. Reset value 0.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped. Reset value 0.
- `busy` output 1: high in every state except IDLE. Reset value 0.

## Operation
- `serial_in` passes through a 2-flop synchronizer, giving `rx_s`. All sampling uses `rx_s`, and only in cycles where `enable` is 1. With `enable` low the FSM, shift register and bit counter hold.
- FSM states: IDLE, DATA, PARITY, STOP. Reset state is IDLE.
- IDLE: on `enable` with `rx_s`=0 (start bit), go to DATA and clear `bit_cnt` to 0. On `enable` with `rx_s`=1, stay in IDLE.
- DATA: on `enable`, shift `rx_s` into the MSB of the shift register (right shift) and increment `bit_cnt`.
  - When the sample taken is number `DATA_BITS`, go to PARITY if `PARITY_EN` is 1, otherwise to STOP.
  - `bit_cnt` is `$clog2(DATA_BITS+1)` bits wide and never wraps within a frame.
- PARITY: on `enable`, latch `par_bad` = XOR of all data bits and `rx_s`. Go to STOP.
- STOP: on `enable`, always return to IDLE.
  - If `rx_s`=0: pulse `frame_error` and discard the byte. No `parity_error` pulse in this case.
  - If `rx_s`=1 and `par_bad` is set: pulse `parity_error` and discard the byte.
  - Otherwise the byte is complete and goes to the output register (see handshake rules).
- Output register handshake:
  - Complete byte with `data_valid`=0: load `data_out`, set `data_valid`.
  - Complete byte with `data_valid`=1 and `data_ready`=1 in the same cycle: load the new byte and keep `data_valid`=1. No overrun.
  - Complete byte with `data_valid`=1 and `data_ready`=0: drop the new byte, keep the old one, pulse `overrun`.
  - Acceptance with no completion in that cycle: clear `data_valid`.
  - `data_out` is stable whenever `data_valid` is 1 and no load occurs.
- A glitch start (the start sample is 0 but the line returns high) is not rejected. The frame completes and is judged at the STOP sample.
- Reset asserted mid-frame: return to IDLE immediately and clear all outputs, the shift register, `bit_cnt` and the synchronizer flops to idle-high.

## Timing
- Synchronizer latency: 2 clocks from a `serial_in` edge to `rx_s`.
- A frame occupies 1 + `DATA_BITS` + `PARITY_EN` + 1 strobes. At 8 clocks per strobe and default parameters, that is 80 clocks.
- `data_valid`, `frame_error`, `parity_error` and `overrun` change on the clock edge where the STOP-sampling `enable` is high.
- `busy` rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- Back-to-back frames: the next start bit is sampled on the very next strobe after the stop bit, with no idle strobe required.

## Structure
- Package `serial_pkg` holds:
  - the FSM state encoding (IDLE, DATA, PARITY, STOP);
  - the constants `LINE_IDLE`=1 and `START_LEVEL`=0;
  - the default `DATA_BITS` value.
- Sub-module `bit_synchronizer` is the 2-flop synchronizer with a parameterised reset level, here 1. It is reused by other receive-side blocks.
- The receiver top level contains the FSM, shift register, bit counter, parity accumulator and output register.

## Test plan
Every scenario drives the eight-clock counter, so `enable` pulses once per 8 clocks. Default parameters unless stated.
- Send 0xA5 (data bits 1,0,1,0,0,1,0,1), stop bit 1, hold `data_ready`=0 -> `data_out`=8'hA5 and `data_valid`=1, held for 100 clocks; assert `data_ready` for 1 cycle -> `data_valid`=0 on the next edge.
- Send 0x3C with the stop bit driven 0 -> one-cycle `frame_error`, `data_valid` stays 0, `busy` returns to 0.
- Send 0x11 then 0x22 back-to-back with `data_ready`=0 -> `data_out`=8'h11 retained and one `overrun` pulse at the end of 0x22; repeat with `data_ready` pulsed on the completion edge -> `data_out`=8'h22 and no overrun.
- With `PARITY_EN`=1, send 0x07 with parity bit 1 -> byte accepted; send 0x07 with parity bit 0 -> `parity_error` pulse and no `data_valid`.
- Assert `reset` low after the 4th data bit of 0xFF, then release and send 0x5A -> all outputs 0 during reset, then `data_out`=8'h5A with no error pulses.
- Hold `serial_in` high for 200 clocks -> `busy`=0 throughout and no output activity.
